// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the 3-stage core control path: opcodes, operand-select
// codes, decode flags and per-stage tracking entries.
package hazard_ctrl_pkg;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011
    } opcode_e;

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_PC  = 2'd1;
    localparam logic [1:0] SEL_IMM = 2'd1;
    localparam logic [1:0] SEL_FWD = 2'd2;

    typedef struct packed {
        logic uses_rs1;
        logic uses_rs2;
        logic writes_rd;
        logic is_load;
        logic a_is_pc;
        logic b_is_rs2;
    } hz_dec_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
        logic       is_load;
    } s2_ent_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
    } s3_ent_t;

endpackage

// File: rtl/hazard_decode.sv
// Combinational register-usage decode of one RV32I instruction; unknown
// opcodes read and write nothing.
module hazard_decode
    import hazard_ctrl_pkg::*;
(
    input  logic [31:0] inst_i,
    output hz_dec_t     dec_o
);

    logic unused_inst_bits;
    assign unused_inst_bits = ^inst_i[31:12];

    always_comb begin
        dec_o = '0;
        case (inst_i[6:0])
            OP_REG: begin
                dec_o.uses_rs1  = 1'b1;
                dec_o.uses_rs2  = 1'b1;
                dec_o.writes_rd = 1'b1;
                dec_o.b_is_rs2  = 1'b1;
            end
            OP_IMM: begin
                dec_o.uses_rs1  = 1'b1;
                dec_o.writes_rd = 1'b1;
            end
            OP_LOAD: begin
                dec_o.uses_rs1  = 1'b1;
                dec_o.writes_rd = 1'b1;
                dec_o.is_load   = 1'b1;
            end
            OP_STORE: begin
                dec_o.uses_rs1 = 1'b1;
                dec_o.uses_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                dec_o.uses_rs1 = 1'b1;
                dec_o.uses_rs2 = 1'b1;
                dec_o.a_is_pc  = 1'b1;
            end
            OP_JALR: begin
                dec_o.uses_rs1  = 1'b1;
                dec_o.writes_rd = 1'b1;
            end
            OP_LUI: begin
                dec_o.writes_rd = 1'b1;
            end
            OP_AUIPC, OP_JAL: begin
                dec_o.writes_rd = 1'b1;
                dec_o.a_is_pc   = 1'b1;
            end
            default: dec_o = '0;
        endcase
        // x0 as destination is never tracked, so it can never match a source.
        if (inst_i[11:7] == 5'd0) begin
            dec_o.writes_rd = 1'b0;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard tracking for S2/S3, S1 stall/flush/freeze generation and registered
// operand-select codes for the instruction entering S2.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] s1_inst,
    input  logic        s1_valid,
    input  logic        br_taken,
    input  logic        mem_busy,
    output logic        stall_s1,
    output logic        flush_s1,
    output logic        freeze,
    output logic [1:0]  a_sel,
    output logic [1:0]  b_sel,
    output logic        rs1_fwd,
    output logic        rs2_fwd,
    output logic        s2_valid,
    output logic        s3_valid
);

    hz_dec_t    dec;
    s2_ent_t    s2_q, s2_d;
    s3_ent_t    s3_q, s3_d;
    logic [1:0] a_sel_q, a_sel_d, b_sel_q, b_sel_d;
    logic       rs1_fwd_q, rs1_fwd_d, rs2_fwd_q, rs2_fwd_d;
    logic [4:0] rs1, rs2, rd;
    logic       hit_rs1, hit_rs2, load_use;

    hazard_decode u_decode (
        .inst_i (s1_inst),
        .dec_o  (dec)
    );

    assign rs1 = s1_inst[19:15];
    assign rs2 = s1_inst[24:20];
    assign rd  = s1_inst[11:7];

    // The S2 producer sits in S3 once the consumer reaches S2; load results
    // are excluded since they only arrive via the RF after the stall.
    assign hit_rs1 = s2_q.valid && s2_q.wr && !s2_q.is_load
                     && (s2_q.rd == rs1) && (rs1 != 5'd0);
    assign hit_rs2 = s2_q.valid && s2_q.wr && !s2_q.is_load
                     && (s2_q.rd == rs2) && (rs2 != 5'd0);

    assign load_use = s1_valid && s2_q.valid && s2_q.is_load && s2_q.wr
                      && ((dec.uses_rs1 && (s2_q.rd == rs1))
                       || (dec.uses_rs2 && (s2_q.rd == rs2)));

    assign freeze = mem_busy;

    always_comb begin
        s2_d      = s2_q;
        s3_d      = s3_q;
        a_sel_d   = a_sel_q;
        b_sel_d   = b_sel_q;
        rs1_fwd_d = rs1_fwd_q;
        rs2_fwd_d = rs2_fwd_q;
        stall_s1  = 1'b0;
        flush_s1  = 1'b0;
        if (mem_busy) begin
            stall_s1 = 1'b1;
        end else begin
            s3_d = '{valid: s2_q.valid, rd: s2_q.rd, wr: s2_q.wr};
            if (br_taken || load_use) begin
                flush_s1  = br_taken;
                stall_s1  = !br_taken;
                s2_d      = '0;
                a_sel_d   = SEL_RF;
                b_sel_d   = SEL_RF;
                rs1_fwd_d = 1'b0;
                rs2_fwd_d = 1'b0;
            end else begin
                s2_d = '{valid: s1_valid, rd: rd, wr: dec.writes_rd,
                         is_load: dec.is_load};
                if (dec.a_is_pc) begin
                    a_sel_d = SEL_PC;
                end else if (dec.uses_rs1 && hit_rs1) begin
                    a_sel_d = SEL_FWD;
                end else begin
                    a_sel_d = SEL_RF;
                end
                if (!dec.b_is_rs2) begin
                    b_sel_d = SEL_IMM;
                end else if (hit_rs2) begin
                    b_sel_d = SEL_FWD;
                end else begin
                    b_sel_d = SEL_RF;
                end
                rs1_fwd_d = hit_rs1;
                rs2_fwd_d = hit_rs2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_q      <= '0;
            s3_q      <= '0;
            a_sel_q   <= SEL_RF;
            b_sel_q   <= SEL_RF;
            rs1_fwd_q <= 1'b0;
            rs2_fwd_q <= 1'b0;
        end else begin
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            a_sel_q   <= a_sel_d;
            b_sel_q   <= b_sel_d;
            rs1_fwd_q <= rs1_fwd_d;
            rs2_fwd_q <= rs2_fwd_d;
        end
    end

    assign a_sel    = a_sel_q;
    assign b_sel    = b_sel_q;
    assign rs1_fwd  = rs1_fwd_q;
    assign rs2_fwd  = rs2_fwd_q;
    assign s2_valid = s2_q.valid;
    assign s3_valid = s3_q.valid;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: inputs change on the falling edge, outputs
// are sampled 1ns later (combinational) or one falling edge later (registered).
module tb_hazard_ctrl;

    localparam logic [31:0] I_ADD_5_1_2  = 32'h002082B3;
    localparam logic [31:0] I_SUB_6_5_3  = 32'h40328333;
    localparam logic [31:0] I_LW_7_1     = 32'h0000A383;
    localparam logic [31:0] I_ADD_8_7_7  = 32'h00738433;
    localparam logic [31:0] I_BEQ_1_2    = 32'h00208063;
    localparam logic [31:0] I_ADDI_0_0_1 = 32'h00100013;
    localparam logic [31:0] I_AUIPC_3    = 32'h00000197;
    localparam logic [31:0] I_ADD_9_3_1  = 32'h001184B3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s1_inst;
    logic        s1_valid, br_taken, mem_busy;
    logic        stall_s1, flush_s1, freeze;
    logic [1:0]  a_sel, b_sel;
    logic        rs1_fwd, rs2_fwd, s2_valid, s3_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s1_inst  (s1_inst),
        .s1_valid (s1_valid),
        .br_taken (br_taken),
        .mem_busy (mem_busy),
        .stall_s1 (stall_s1),
        .flush_s1 (flush_s1),
        .freeze   (freeze),
        .a_sel    (a_sel),
        .b_sel    (b_sel),
        .rs1_fwd  (rs1_fwd),
        .rs2_fwd  (rs2_fwd),
        .s2_valid (s2_valid),
        .s3_valid (s3_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic comb_chk(input string tag, input logic st, input logic fl, input logic fz);
        #1;
        chk({tag, ".stall"},  {31'd0, stall_s1}, {31'd0, st});
        chk({tag, ".flush"},  {31'd0, flush_s1}, {31'd0, fl});
        chk({tag, ".freeze"}, {31'd0, freeze},   {31'd0, fz});
    endtask

    task automatic reg_chk(input string tag, input logic v2, input logic v3,
                           input logic [1:0] a, input logic [1:0] b,
                           input logic f1, input logic f2);
        chk({tag, ".s2v"},  {31'd0, s2_valid}, {31'd0, v2});
        chk({tag, ".s3v"},  {31'd0, s3_valid}, {31'd0, v3});
        chk({tag, ".asel"}, {30'd0, a_sel},    {30'd0, a});
        chk({tag, ".bsel"}, {30'd0, b_sel},    {30'd0, b});
        chk({tag, ".f1"},   {31'd0, rs1_fwd},  {31'd0, f1});
        chk({tag, ".f2"},   {31'd0, rs2_fwd},  {31'd0, f2});
    endtask

    task automatic drive(input logic [31:0] inst, input logic v, input logic br, input logic busy);
        s1_inst  = inst;
        s1_valid = v;
        br_taken = br;
        mem_busy = busy;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reg_chk("reset", 0, 0, 0, 0, 0, 0);
        comb_chk("reset", 0, 0, 0);
        rst_n = 1'b1;

        // back-to-back ALU dependency: no stall, forward from S3
        drive(I_ADD_5_1_2, 1, 0, 0);
        comb_chk("add", 0, 0, 0);
        tick();
        reg_chk("add", 1, 0, 0, 0, 0, 0);
        drive(I_SUB_6_5_3, 1, 0, 0);
        comb_chk("sub", 0, 0, 0);
        tick();
        reg_chk("sub", 1, 1, 2, 0, 1, 0);

        // load-use: one bubble, then consumer reads the RF
        drive(I_LW_7_1, 1, 0, 0);
        tick();
        reg_chk("lw", 1, 1, 0, 1, 0, 0);
        drive(I_ADD_8_7_7, 1, 0, 0);
        comb_chk("ldu", 1, 0, 0);
        tick();
        reg_chk("ldu_bubble", 0, 1, 0, 0, 0, 0);
        comb_chk("ldu_release", 0, 0, 0);
        tick();
        reg_chk("ldu_add", 1, 0, 0, 0, 0, 0);

        // taken branch in S2 flushes S1
        drive(I_BEQ_1_2, 1, 0, 0);
        tick();
        reg_chk("beq", 1, 1, 1, 1, 0, 0);
        drive(I_ADD_8_7_7, 1, 1, 0);
        comb_chk("br", 0, 1, 0);
        tick();
        reg_chk("br", 0, 1, 0, 0, 0, 0);

        // redirect outranks a pending load-use stall
        drive(I_LW_7_1, 1, 0, 0);
        tick();
        reg_chk("lw2", 1, 0, 0, 1, 0, 0);
        drive(I_ADD_8_7_7, 1, 1, 0);
        comb_chk("br_ldu", 0, 1, 0);
        tick();
        reg_chk("br_ldu", 0, 1, 0, 0, 0, 0);

        // x0 producer never forwards
        drive(I_ADDI_0_0_1, 1, 0, 0);
        tick();
        reg_chk("addi", 1, 0, 0, 1, 0, 0);
        drive(I_AUIPC_3, 1, 0, 0);
        comb_chk("auipc", 0, 0, 0);
        tick();
        reg_chk("auipc", 1, 1, 1, 1, 0, 0);

        // freeze for 3 cycles; a branch pulse during freeze is ignored
        for (int i = 0; i < 3; i++) begin
            drive(I_ADD_9_3_1, 1, (i == 1), 1);
            comb_chk("busy", 1, 0, 1);
            tick();
            reg_chk("busy", 1, 1, 1, 1, 0, 0);
        end
        drive(I_ADD_9_3_1, 1, 0, 0);
        comb_chk("unbusy", 0, 0, 0);
        tick();
        reg_chk("unbusy", 1, 1, 2, 0, 1, 0);

        // reset during a load-use stall discards tracked state
        drive(I_LW_7_1, 1, 0, 0);
        tick();
        drive(I_ADD_8_7_7, 1, 0, 0);
        comb_chk("pre_rst", 1, 0, 0);
        rst_n = 1'b0;
        tick();
        reg_chk("mid_rst", 0, 0, 0, 0, 0, 0);
        comb_chk("mid_rst", 0, 0, 0);
        rst_n = 1'b1;
        drive(32'd0, 0, 0, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
